kf8259_acknowledge_sequencer: RTL and testbench
===============================================

// Module: kf8259_acknowledge_sequencer
// PURPOSE
//  CPU-facing end of the KF8259 interrupt path. Consumes the one-hot grant from the
//  priority resolver and raises INT to the CPU. Runs the INTA# pulse sequence for
//  8086 mode (2 pulses) or MCS-80 mode (3 pulses), drives the vector/CALL bytes and
//  owns the in-service register (ISR), including set, EOI clear and auto-EOI.
//  Returns in_service_register and highest_level_in_service to the resolver.
// PARAMETERS
//  none; widths are fixed by the 8259 architecture (8 IR levels).
// PORTS
//  clock                     in   1  system clock; single clock domain
//  reset                     in   1  synchronous, active-high reset
//  interrupt                 in   8  one-hot grant from resolver; 0 = none
//  interrupt_acknowledge_n   in   1  INTA#, already synchronised to clock
//  u8086_mode                in   1  1 = 8086 (2 pulses), 0 = MCS-80 (3 pulses)
//  auto_eoi                  in   1  clear ISR bit at end of the last INTA pulse
//  call_address_interval_4   in   1  MCS-80 only: 1 = interval 4, 0 = interval 8
//  vector_base               in   8  8086: T7..T3 in [7:3]; MCS-80: A7..A5/A6 in [7:5]
//  upper_address             in   8  MCS-80 A15..A8
//  end_of_interrupt          in   8  one-cycle bit mask of ISR bits to clear
//  init_clear                in   1  ICW1 write pulse; same effect as reset
//  priority_rotate           in   3  lowest-priority IR level (7 = IR0 highest)
//  interrupt_to_cpu          out  1  INT
//  clear_interrupt_request   out  8  one-cycle pulse: clear this IRR bit
//  in_service_register       out  8  ISR
//  highest_level_in_service  out  8  one-hot highest-priority set ISR bit, or 0
//  ack_data                  out  8  byte for the CPU data bus
//  ack_data_enable           out  1  drive ack_data onto the bus
// BEHAVIOUR
//  - Reset/init_clear: state IDLE, ISR=0, all outputs 0, latched level=7, inta_prev=1.
//    Both take priority over every other event, including in mid-sequence.
//  - INTA edges: inta_prev register. fall = prev&~now, rise = ~prev&now.
//  - FSM states: IDLE, ACK1, ACK2, ACK3.
//    IDLE --fall--> ACK1. ACK1 --fall--> ACK2.
//    ACK2 --rise--> IDLE in 8086 mode. ACK2 --fall--> ACK3 in MCS-80 mode.
//    ACK3 --rise--> IDLE.
//    A rising edge in ACK1 leaves the state unchanged.
//  - INT: registered. Sets 1 cycle after interrupt!=0 while in IDLE. Clears on the
//    first fall. Stays 0 until the FSM returns to IDLE.
//  - First fall: freezes level = encode(interrupt). If interrupt!=0, ISR[level] is set
//    and clear_interrupt_request[level] pulses for 1 cycle.
//    If interrupt==0 (spurious), level=7 and ISR/IRR are untouched.
//  - Bytes, registered, valid the cycle after the fall; enable drops the cycle after the rise.
//    8086: pulse1 drives nothing; pulse2 = {vector_base[7:3], level}.
//    MCS-80: pulse1 = 8'hCD.
//      pulse2 = interval4 ? {vb[7:5], level, 2'b00} : {vb[7:6], level, 3'b000}.
//      pulse3 = upper_address.
//  - Auto-EOI: ISR[level] clears on the rise that returns the FSM to IDLE (non-spurious only).
//  - ISR update per cycle: ISR <= (ISR & ~end_of_interrupt) | set_mask.
//    A set on the same bit wins over a same-cycle EOI.
//  - highest_level_in_service (combinational from ISR) =
//    rotate_left(resolve_priority(rotate_right(ISR, priority_rotate)), priority_rotate).
//  - A fall arriving in IDLE while interrupt==0 is still handled as a spurious sequence.
// STRUCTURE
//  - Package kf8259_common_pkg holds:
//    functions rotate_right, rotate_left, resolve_priority, onehot_to_index;
//    constant CALL_OPCODE = 8'hCD;
//    enum ack_state_t {IDLE, ACK1, ACK2, ACK3}.
//  - No sub-module: the FSM, ISR and byte mux are one always_ff plus comb logic.
// TESTING
//  1. 8086, vb=8'h40, interrupt=8'h08, two INTA pulses
//     -> INT=1 next cycle, 0 after fall1; clear_irr=8'h08 pulse; ISR=8'h08;
//        pulse2 ack_data=8'h43, enable=1.
//  2. Test 1 with auto_eoi=1 -> ISR returns to 8'h00 on the pulse-2 rise; INT re-asserts
//     if interrupt still !=0.
//  3. MCS-80, vb=8'hE0, upper=8'h12, level 5, interval4=1 -> bytes CD, F4, 12.
//     Repeat with interval4=0 -> CD, E8, 12.
//  4. Spurious: interrupt=0 at fall1 -> no clear_irr pulse, ISR unchanged; 8086 vb=8'h40
//     -> ack_data=8'h47.
//  5. ISR=8'h81: rotate=7 -> highest=8'h01; rotate=6 -> highest=8'h80.
//     EOI=8'h08 in the same cycle as a set of bit 3 -> bit 3 stays set.
//  6. reset (and separately init_clear) asserted in ACK2 -> ISR=0, INT=0, enable=0, IDLE;
//     the next fall is treated as pulse 1.

Source files
------------

// File: rtl/kf8259_common_pkg.sv
// Shared types, constants and helpers for the KF8259 interrupt path.
package kf8259_common_pkg;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2,
    ACK3 = 2'd3
  } ack_state_t;

  // Rotate right by (rotate + 1) mod 8, so rotate = 7 is the identity
  // and IR0 ends up in bit 0 when IR0 is the highest priority level.
  function automatic logic [7:0] rotate_right(input logic [7:0] source,
                                              input logic [2:0] rotate);
    logic [15:0] doubled;
    logic [2:0]  amount;
    amount  = rotate + 3'd1;
    doubled = {source, source} >> amount;
    return doubled[7:0];
  endfunction

  // Inverse of rotate_right.
  function automatic logic [7:0] rotate_left(input logic [7:0] source,
                                             input logic [2:0] rotate);
    logic [15:0] doubled;
    logic [2:0]  amount;
    amount  = rotate + 3'd1;
    doubled = {source, source} << amount;
    return doubled[15:8];
  endfunction

  // Keep only the lowest set bit (bit 0 is the highest priority).
  function automatic logic [7:0] resolve_priority(input logic [7:0] source);
    return source & (~source + 8'd1);
  endfunction

  // Index of a one-hot vector; an all-zero input encodes as 7, which is
  // exactly the level reported for a spurious acknowledge.
  function automatic logic [2:0] onehot_to_index(input logic [7:0] source);
    logic [2:0] index;
    index = 3'd7;
    for (int i = 0; i < 8; i++) begin
      if (source[i]) index = 3'(i);
    end
    return index;
  endfunction

endpackage

// File: rtl/kf8259_acknowledge_sequencer.sv
// CPU-facing end of the KF8259: raises INT, sequences the INTA# pulses for
// 8086 (2 pulses) or MCS-80 (3 pulses), drives the vector / CALL bytes and
// owns the in-service register.
module kf8259_acknowledge_sequencer
  import kf8259_common_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] interrupt,
  input  logic       interrupt_acknowledge_n,
  input  logic       u8086_mode,
  input  logic       auto_eoi,
  input  logic       call_address_interval_4,
  input  logic [7:0] vector_base,
  input  logic [7:0] upper_address,
  input  logic [7:0] end_of_interrupt,
  input  logic       init_clear,
  input  logic [2:0] priority_rotate,
  output logic       interrupt_to_cpu,
  output logic [7:0] clear_interrupt_request,
  output logic [7:0] in_service_register,
  output logic [7:0] highest_level_in_service,
  output logic [7:0] ack_data,
  output logic       ack_data_enable,
  output ack_state_t debug_state
);

  // Handshake: INTA# is active low and already synchronised. A falling edge
  // starts a bus pulse and the byte for it is presented (ack_data_enable=1)
  // the cycle after that fall; the byte is withdrawn the cycle after the
  // matching rising edge. There is no back-pressure.

  ack_state_t state;
  ack_state_t state_next;
  logic       inta_prev;
  logic       inta_fall;
  logic       inta_rise;
  logic [2:0] level;
  logic       spurious;
  logic       first_fall;
  logic       sequence_done;
  logic [7:0] set_mask;
  logic [7:0] auto_clear_mask;
  logic [7:0] byte_next;
  logic       byte_valid_next;

  assign inta_fall   = inta_prev & ~interrupt_acknowledge_n;
  assign inta_rise   = ~inta_prev & interrupt_acknowledge_n;
  assign debug_state = state;

  // Next-state logic for the INTA# pulse sequence.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (inta_fall) state_next = ACK1;
      ACK1: if (inta_fall) state_next = ACK2;
      ACK2: begin
        if (u8086_mode && inta_rise) state_next = IDLE;
        else if (!u8086_mode && inta_fall) state_next = ACK3;
      end
      ACK3: if (inta_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ISR set / auto-EOI clear masks derived from the sequence position.
  always_comb begin
    first_fall      = (state == IDLE) && inta_fall;
    sequence_done   = (state != IDLE) && (state_next == IDLE);
    set_mask        = 8'h00;
    auto_clear_mask = 8'h00;
    if (first_fall && (interrupt != 8'h00))
      set_mask = 8'h01 << onehot_to_index(interrupt);
    if (sequence_done && auto_eoi && !spurious)
      auto_clear_mask = 8'h01 << level;
  end

  // Byte to present for the pulse that the current falling edge opens.
  always_comb begin
    byte_next       = 8'h00;
    byte_valid_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (!u8086_mode) begin
          byte_next       = CALL_OPCODE;
          byte_valid_next = 1'b1;
        end
      end
      ACK1: begin
        byte_valid_next = 1'b1;
        if (u8086_mode)
          byte_next = {vector_base[7:3], level};
        else if (call_address_interval_4)
          byte_next = {vector_base[7:5], level, 2'b00};
        else
          byte_next = {vector_base[7:6], level, 3'b000};
      end
      ACK2: begin
        if (!u8086_mode) begin
          byte_next       = upper_address;
          byte_valid_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Highest-priority in-service level under the current rotation.
  always_comb begin
    highest_level_in_service =
      rotate_left(resolve_priority(rotate_right(in_service_register, priority_rotate)),
                  priority_rotate);
  end

  // State, edge history, ISR, INT and bus byte registers.
  always_ff @(posedge clock) begin
    if (reset || init_clear) begin
      state                   <= IDLE;
      inta_prev               <= 1'b1;
      level                   <= 3'd7;
      spurious                <= 1'b0;
      in_service_register     <= 8'h00;
      clear_interrupt_request <= 8'h00;
      interrupt_to_cpu        <= 1'b0;
      ack_data                <= 8'h00;
      ack_data_enable         <= 1'b0;
    end else begin
      state                   <= state_next;
      inta_prev               <= interrupt_acknowledge_n;
      clear_interrupt_request <= set_mask;
      // A set on the same bit beats a same-cycle EOI.
      in_service_register     <= (in_service_register & ~end_of_interrupt & ~auto_clear_mask)
                                 | set_mask;
      interrupt_to_cpu        <= (state == IDLE) && !inta_fall && (interrupt != 8'h00);
      if (first_fall) begin
        level    <= onehot_to_index(interrupt);
        spurious <= (interrupt == 8'h00);
      end
      if (inta_fall) begin
        ack_data        <= byte_next;
        ack_data_enable <= byte_valid_next;
      end else if (inta_rise) begin
        ack_data        <= 8'h00;
        ack_data_enable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kf8259_acknowledge_sequencer.sv
// Directed, table-driven bench for the KF8259 acknowledge sequencer.
module tb_kf8259_acknowledge_sequencer;
  import kf8259_common_pkg::*;

  localparam int W = 36;

  // Clock / reset
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] interrupt = 8'h00;
  logic       interrupt_acknowledge_n = 1'b1;
  logic       u8086_mode = 1'b1;
  logic       auto_eoi = 1'b0;
  logic       call_address_interval_4 = 1'b0;
  logic [7:0] vector_base = 8'h00;
  logic [7:0] upper_address = 8'h00;
  logic [7:0] end_of_interrupt = 8'h00;
  logic       init_clear = 1'b0;
  logic [2:0] priority_rotate = 3'd7;
  logic       interrupt_to_cpu;
  logic [7:0] clear_interrupt_request;
  logic [7:0] in_service_register;
  logic [7:0] highest_level_in_service;
  logic [7:0] ack_data;
  logic       ack_data_enable;
  ack_state_t debug_state;

  always #5 clock = ~clock;

  kf8259_acknowledge_sequencer dut (
    .clock                    (clock),
    .reset                    (reset),
    .interrupt                (interrupt),
    .interrupt_acknowledge_n  (interrupt_acknowledge_n),
    .u8086_mode               (u8086_mode),
    .auto_eoi                 (auto_eoi),
    .call_address_interval_4  (call_address_interval_4),
    .vector_base              (vector_base),
    .upper_address            (upper_address),
    .end_of_interrupt         (end_of_interrupt),
    .init_clear               (init_clear),
    .priority_rotate          (priority_rotate),
    .interrupt_to_cpu         (interrupt_to_cpu),
    .clear_interrupt_request  (clear_interrupt_request),
    .in_service_register      (in_service_register),
    .highest_level_in_service (highest_level_in_service),
    .ack_data                 (ack_data),
    .ack_data_enable          (ack_data_enable),
    .debug_state              (debug_state)
  );

  typedef struct {
    logic       rst;
    logic       initc;
    logic [7:0] irq;
    logic       inta_n;
    logic [7:0] eoi;
    logic       mode;
    logic       aeoi;
    logic       iv4;
    logic [7:0] vb;
    logic [7:0] ua;
    logic [2:0] rot;
    logic [W-1:0] expected; // {int, clr, isr, hi, data, en, state}
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] exp_q[$];
  int           vectors_applied = 0;
  int           miscompares = 0;

  // Static configuration picked up by the vectors that follow a cfg() call.
  logic       c_mode = 1'b1;
  logic       c_aeoi = 1'b0;
  logic       c_iv4 = 1'b0;
  logic [7:0] c_vb = 8'h00;
  logic [7:0] c_ua = 8'h00;
  logic [2:0] c_rot = 3'd7;

  task automatic cfg(input logic mode, input logic aeoi, input logic iv4,
                     input logic [7:0] vb, input logic [7:0] ua, input logic [2:0] rot);
    c_mode = mode; c_aeoi = aeoi; c_iv4 = iv4; c_vb = vb; c_ua = ua; c_rot = rot;
  endtask

  function automatic vec_t mk(input logic rst, input logic initc, input logic [7:0] irq,
                              input logic inta_n, input logic [7:0] eoi,
                              input logic e_int, input logic [7:0] e_clr,
                              input logic [7:0] e_isr, input logic [7:0] e_hi,
                              input logic [7:0] e_data, input logic e_en,
                              input logic [1:0] e_st);
    vec_t x;
    x.rst = rst; x.initc = initc; x.irq = irq; x.inta_n = inta_n; x.eoi = eoi;
    x.mode = c_mode; x.aeoi = c_aeoi; x.iv4 = c_iv4; x.vb = c_vb; x.ua = c_ua;
    x.rot = c_rot;
    x.expected = {e_int, e_clr, e_isr, e_hi, e_data, e_en, e_st};
    return x;
  endfunction

  task automatic v(input logic rst, input logic initc, input logic [7:0] irq,
                   input logic inta_n, input logic [7:0] eoi,
                   input logic e_int, input logic [7:0] e_clr, input logic [7:0] e_isr,
                   input logic [7:0] e_hi, input logic [7:0] e_data, input logic e_en,
                   input logic [1:0] e_st);
    vecs.push_back(mk(rst, initc, irq, inta_n, eoi, e_int, e_clr, e_isr, e_hi,
                      e_data, e_en, e_st));
  endtask

  // Driver + scoreboard: drive one cycle of inputs, sample 1 time unit after
  // the rising edge and compare against the queued expectation.
  task automatic apply(input vec_t x, input string tag);
    logic [W-1:0] got;
    logic [W-1:0] want;
    reset                   = x.rst;
    init_clear              = x.initc;
    interrupt               = x.irq;
    interrupt_acknowledge_n = x.inta_n;
    end_of_interrupt        = x.eoi;
    u8086_mode              = x.mode;
    auto_eoi                = x.aeoi;
    call_address_interval_4 = x.iv4;
    vector_base             = x.vb;
    upper_address           = x.ua;
    priority_rotate         = x.rot;
    exp_q.push_back(x.expected);
    @(posedge clock);
    #1;
    got  = {interrupt_to_cpu, clear_interrupt_request, in_service_register,
            highest_level_in_service, ack_data, ack_data_enable, debug_state};
    want = exp_q.pop_front();
    vectors_applied++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got int=%b clr=%h isr=%h hi=%h data=%h en=%b st=%0d, required int=%b clr=%h isr=%h hi=%h data=%h en=%b st=%0d",
               tag, got[35], got[34:27], got[26:19], got[18:11], got[10:3], got[2], got[1:0],
               want[35], want[34:27], want[26:19], want[18:11], want[10:3], want[2], want[1:0]);
    end
  endtask

  initial begin
    // ---- 8086, vb=40, level 3 ----
    cfg(1'b1, 1'b0, 1'b0, 8'h40, 8'h00, 3'd7);
    v(1,0,8'h00,1,8'h00, 0,8'h00,8'h00,8'h00,8'h00,0,0);
    v(1,0,8'h00,1,8'h00, 0,8'h00,8'h00,8'h00,8'h00,0,0);
    v(0,0,8'h08,1,8'h00, 1,8'h00,8'h00,8'h00,8'h00,0,0);
    v(0,0,8'h08,0,8'h00, 0,8'h08,8'h08,8'h08,8'h00,0,1);
    v(0,0,8'h00,0,8'h00, 0,8'h00,8'h08,8'h08,8'h00,0,1);
    v(0,0,8'h00,1,8'h00, 0,8'h00,8'h08,8'h08,8'h00,0,1);
    v(0,0,8'h00,0,8'h00, 0,8'h00,8'h08,8'h08,8'h43,1,2);
    v(0,0,8'h00,0,8'h00, 0,8'h00,8'h08,8'h08,8'h43,1,2);
    v(0,0,8'h00,1,8'h00, 0,8'h00,8'h08,8'h08,8'h00,0,0);
    v(0,0,8'h00,1,8'h00, 0,8'h00,8'h08,8'h08,8'h00,0,0);
    v(0,0,8'h00,1,8'h08, 0,8'h00,8'h00,8'h00,8'h00,0,0);
    // ---- set of bit 3 beats a same-cycle EOI of bit 3 ----
    v(0,0,8'h08,1,8'h00, 1,8'h00,8'h00,8'h00,8'h00,0,0);
    v(0,0,8'h08,0,8'h08, 0,8'h08,8'h08,8'h08,8'h00,0,1);
    v(0,0,8'h00,1,8'h00, 0,8'h00,8'h08,8'h08,8'h00,0,1);
    v(0,0,8'h00,0,8'h00, 0,8'h00,8'h08,8'h08,8'h43,1,2);
    v(0,0,8'h00,1,8'h00, 0,8'h00,8'h08,8'h08,8'h00,0,0);
    v(0,0,8'h00,1,8'h08, 0,8'h00,8'h00,8'h00,8'h00,0,0);
    // ---- auto-EOI, request still pending afterwards ----
    cfg(1'b1, 1'b1, 1'b0, 8'h40, 8'h00, 3'd7);
    v(0,0,8'h08,1,8'h00, 1,8'h00,8'h00,8'h00,8'h00,0,0);
    v(0,0,8'h08,0,8'h00, 0,8'h08,8'h08,8'h08,8'h00,0,1);
    v(0,0,8'h08,1,8'h00, 0,8'h00,8'h08,8'h08,8'h00,0,1);
    v(0,0,8'h08,0,8'h00, 0,8'h00,8'h08,8'h08,8'h43,1,2);
    v(0,0,8'h08,1,8'h00, 0,8'h00,8'h00,8'h00,8'h00,0,0);
    v(0,0,8'h08,1,8'h00, 1,8'h00,8'h00,8'h00,8'h00,0,0);
    v(0,0,8'h00,1,8'h00, 0,8'h00,8'h00,8'h00,8'h00,0,0);
    // ---- build ISR=81 (levels 0 and 7) ----
    cfg(1'b1, 1'b0, 1'b0, 8'h40, 8'h00, 3'd7);
    v(0,0,8'h01,1,8'h00, 1,8'h00,8'h00,8'h00,8'h00,0,0);
    v(0,0,8'h01,0,8'h00, 0,8'h01,8'h01,8'h01,8'h00,0,1);
    v(0,0,8'h00,1,8'h00, 0,8'h00,8'h01,8'h01,8'h00,0,1);
    v(0,0,8'h00,0,8'h00, 0,8'h00,8'h01,8'h01,8'h40,1,2);
    v(0,0,8'h00,1,8'h00, 0,8'h00,8'h01,8'h01,8'h00,0,0);
    v(0,0,8'h80,1,8'h00, 1,8'h00,8'h01,8'h01,8'h00,0,0);
    v(0,0,8'h80,0,8'h00, 0,8'h80,8'h81,8'h01,8'h00,0,1);
    v(0,0,8'h00,1,8'h00, 0,8'h00,8'h81,8'h01,8'h00,0,1);
    v(0,0,8'h00,0,8'h00, 0,8'h00,8'h81,8'h01,8'h47,1,2);
    v(0,0,8'h00,1,8'h00, 0,8'h00,8'h81,8'h01,8'h00,0,0);
    // ---- rotation: IR7 lowest -> bit 0 wins; IR6 lowest -> bit 7 wins ----
    cfg(1'b1, 1'b0, 1'b0, 8'h40, 8'h00, 3'd6);
    v(0,0,8'h00,1,8'h00, 0,8'h00,8'h81,8'h80,8'h00,0,0);
    // ---- spurious (auto-EOI on: must not clear ISR bit 7) ----
    cfg(1'b1, 1'b1, 1'b0, 8'h40, 8'h00, 3'd7);
    v(0,0,8'h00,0,8'h00, 0,8'h00,8'h81,8'h01,8'h00,0,1);
    v(0,0,8'h00,1,8'h00, 0,8'h00,8'h81,8'h01,8'h00,0,1);
    v(0,0,8'h00,0,8'h00, 0,8'h00,8'h81,8'h01,8'h47,1,2);
    v(0,0,8'h00,1,8'h00, 0,8'h00,8'h81,8'h01,8'h00,0,0);
    v(0,0,8'h00,1,8'h81, 0,8'h00,8'h00,8'h00,8'h00,0,0);
    // ---- MCS-80, level 5, interval 4 ----
    cfg(1'b0, 1'b0, 1'b1, 8'hE0, 8'h12, 3'd7);
    v(0,0,8'h20,1,8'h00, 1,8'h00,8'h00,8'h00,8'h00,0,0);
    v(0,0,8'h20,0,8'h00, 0,8'h20,8'h20,8'h20,8'hCD,1,1);
    v(0,0,8'h00,1,8'h00, 0,8'h00,8'h20,8'h20,8'h00,0,1);
    v(0,0,8'h00,0,8'h00, 0,8'h00,8'h20,8'h20,8'hF4,1,2);
    v(0,0,8'h00,1,8'h00, 0,8'h00,8'h20,8'h20,8'h00,0,2);
    v(0,0,8'h00,0,8'h00, 0,8'h00,8'h20,8'h20,8'h12,1,3);
    v(0,0,8'h00,1,8'h00, 0,8'h00,8'h20,8'h20,8'h00,0,0);
    v(0,0,8'h00,1,8'h20, 0,8'h00,8'h00,8'h00,8'h00,0,0);
    // ---- MCS-80, level 5, interval 8 ----
    cfg(1'b0, 1'b0, 1'b0, 8'hE0, 8'h12, 3'd7);
    v(0,0,8'h20,1,8'h00, 1,8'h00,8'h00,8'h00,8'h00,0,0);
    v(0,0,8'h20,0,8'h00, 0,8'h20,8'h20,8'h20,8'hCD,1,1);
    v(0,0,8'h00,1,8'h00, 0,8'h00,8'h20,8'h20,8'h00,0,1);
    v(0,0,8'h00,0,8'h00, 0,8'h00,8'h20,8'h20,8'hE8,1,2);
    v(0,0,8'h00,1,8'h00, 0,8'h00,8'h20,8'h20,8'h00,0,2);
    v(0,0,8'h00,0,8'h00, 0,8'h00,8'h20,8'h20,8'h12,1,3);
    v(0,0,8'h00,1,8'h00, 0,8'h00,8'h20,8'h20,8'h00,0,0);

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // ---- hand sequence: reset in ACK2 (ISR still holds bit 5) ----
    cfg(1'b1, 1'b0, 1'b0, 8'h40, 8'h00, 3'd7);
    apply(mk(0,0,8'h04,1,8'h00, 1,8'h00,8'h20,8'h20,8'h00,0,0), "rst_int");
    apply(mk(0,0,8'h04,0,8'h00, 0,8'h04,8'h24,8'h04,8'h00,0,1), "rst_fall1");
    apply(mk(0,0,8'h00,1,8'h00, 0,8'h00,8'h24,8'h04,8'h00,0,1), "rst_rise1");
    apply(mk(0,0,8'h00,0,8'h00, 0,8'h00,8'h24,8'h04,8'h42,1,2), "rst_fall2");
    apply(mk(1,0,8'h04,1,8'h00, 0,8'h00,8'h00,8'h00,8'h00,0,0), "rst_in_ack2");
    apply(mk(0,0,8'h02,1,8'h00, 1,8'h00,8'h00,8'h00,8'h00,0,0), "rst_after");
    // ---- hand sequence: init_clear in ACK2 with INTA# held low ----
    apply(mk(0,0,8'h02,0,8'h00, 0,8'h02,8'h02,8'h02,8'h00,0,1), "ic_fall1");
    apply(mk(0,0,8'h00,1,8'h00, 0,8'h00,8'h02,8'h02,8'h00,0,1), "ic_rise1");
    apply(mk(0,0,8'h00,0,8'h00, 0,8'h00,8'h02,8'h02,8'h41,1,2), "ic_fall2");
    apply(mk(0,1,8'h02,0,8'h00, 0,8'h00,8'h00,8'h00,8'h00,0,0), "ic_in_ack2");
    apply(mk(0,0,8'h00,0,8'h00, 0,8'h00,8'h00,8'h00,8'h00,0,1), "ic_next_pulse1");
    apply(mk(0,0,8'h00,1,8'h00, 0,8'h00,8'h00,8'h00,8'h00,0,1), "ic_rise");
    apply(mk(0,0,8'h00,0,8'h00, 0,8'h00,8'h00,8'h00,8'h47,1,2), "ic_pulse2");
    apply(mk(0,0,8'h00,1,8'h00, 0,8'h00,8'h00,8'h00,8'h00,0,0), "ic_done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
